address_decoding: RTL and testbench
===================================

Name: address_decoding

Overview:
- Decodes the 17-bit system bus address into chip-enable and attribute flags for the PET memory map.
- Targets are RAM/ROM backing store, the magic control registers, PIA1, PIA2, VIA and CRTC.
- Sits between the bus arbiter/CPU address path and the memory and I/O peripheral selects.
- Decode is combinational by default; an optional output register stage is available.

Parameters:
- None.

Ports:
- clk_i  input  1  system clock; used only when ADDR_DECODE_REG_EN is defined.
- reset_i  input  1  synchronous active-high reset; used only when ADDR_DECODE_REG_EN is defined.
- bus_addr_i  input  17  bus address; bit 16 selects the upper 64 KB bank.
- ram_en_o  output  1  RAM/ROM backing store select.
- magic_en_o  output  1  magic control register select.
- pia1_en_o  output  1  PIA1 select.
- pia2_en_o  output  1  PIA2 select.
- via_en_o  output  1  VIA select.
- crtc_en_o  output  1  CRTC select.
- io_en_o  output  1  asserted for any of PIA1, PIA2, VIA or CRTC.
- is_mirrored_o  output  1  address lies in the mirrored display RAM window.
- is_readonly_o  output  1  address lies in ROM; writes must be suppressed downstream.

Interface note: one clock; reset is synchronous and active-high.

Behaviour:
- Decoding for bus_addr_i[16] = 0, with A = bus_addr_i[15:0]; outputs not listed are 0:
  - $0000-$7FFF (RAM): ram_en=1.
  - $8000-$8FFF (display RAM): ram_en=1, is_mirrored=1.
  - $9000-$E7FF (ROM): ram_en=1, is_readonly=1.
  - $E800-$E80F (magic): magic_en=1. io_en stays 0 and ram_en stays 0.
  - $E810-$E81F: pia1_en=1, io_en=1.
  - $E820-$E83F: pia2_en=1, io_en=1.
  - $E840-$E87F: via_en=1, io_en=1.
  - $E880-$E8FF: crtc_en=1, io_en=1.
  - $E900-$EFFF: unmapped; all outputs 0.
  - $F000-$FFFF (ROM): ram_en=1, is_readonly=1.
- When bus_addr_i[16] = 1 (upper bank, any low address): ram_en=1 and all other outputs 0.
  - The upper bank is never I/O, never mirrored and never read-only.
- Exclusivity: at most one of ram_en, magic_en, pia1_en, pia2_en, via_en, crtc_en is high at any time.
- io_en_o equals the OR of pia1_en, pia2_en, via_en and crtc_en.
- Range boundaries are exact and inclusive; each boundary pair (e.g. $7FFF/$8000, $E80F/$E810, $E8FF/$E900) must switch region.
- Outputs must be fully defined (0/1, never X) for every defined address value.
- Latency without the feature: purely combinational; outputs valid within one delta of a bus_addr_i change.
  - clk_i and reset_i are ignored in this mode.
  - No state is kept in this mode.

Optional Feature:
ADDR_DECODE_REG_EN:
- Defined:
  - All nine outputs are registered on the rising edge of clk_i.
  - They reflect the bus_addr_i sampled at the previous edge, giving exactly one cycle of latency.
  - While reset_i is high at a clock edge, all outputs are forced to 0 at that edge.
  - Outputs remain 0 until the first edge after reset_i deasserts, then track the decode.
- Not defined: combinational decode as described in Behaviour; no registers are inferred.

Test Plan:
- Sweep $00000-$07FFF -> ram_en=1 only; all other outputs 0.
- Sweep $08000-$08FFF -> ram_en=1 and is_mirrored=1 only.
- Sweep $09000-$0E7FF and $0F000-$0FFFF -> ram_en=1 and is_readonly=1 only.
- Sweep $0E800-$0E8FF:
  - $E800-$E80F -> magic_en only.
  - $E810-$E81F -> pia1_en with io_en.
  - $E820-$E83F -> pia2_en with io_en.
  - $E840-$E87F -> via_en with io_en.
  - $E880-$E8FF -> crtc_en with io_en.
- Addresses $0E900, $0EFFF -> all outputs 0. Addresses $10000, $1E810, $1FFFF -> ram_en=1 only.
- With ADDR_DECODE_REG_EN defined:
  - Hold reset_i=1 for 2 edges with address $0E810 -> all outputs 0.
  - Release reset_i -> pia1_en=1 and io_en=1 after the next edge.
  - Change address to $08000 -> ram_en=1 and is_mirrored=1 exactly one edge later.

Source files
------------

// File: rtl/address_decoding.sv
// PET memory-map decoder: 17-bit bus address to chip enables and attribute flags.
// Define ADDR_DECODE_REG_EN to register all outputs (one cycle latency, sync reset).
module address_decoding (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [16:0] bus_addr_i,
    output logic        ram_en_o,
    output logic        magic_en_o,
    output logic        pia1_en_o,
    output logic        pia2_en_o,
    output logic        via_en_o,
    output logic        crtc_en_o,
    output logic        io_en_o,
    output logic        is_mirrored_o,
    output logic        is_readonly_o
);

    logic [15:0] addrLo;
    logic        upperBank;

    logic ram_en_d;
    logic magic_en_d;
    logic pia1_en_d;
    logic pia2_en_d;
    logic via_en_d;
    logic crtc_en_d;
    logic io_en_d;
    logic is_mirrored_d;
    logic is_readonly_d;

    assign addrLo    = bus_addr_i[15:0];
    assign upperBank = bus_addr_i[16];

    // The $E8xx page is split on the low byte; everything else is a coarse range compare.
    always_comb begin
        ram_en_d      = 1'b0;
        magic_en_d    = 1'b0;
        pia1_en_d     = 1'b0;
        pia2_en_d     = 1'b0;
        via_en_d      = 1'b0;
        crtc_en_d     = 1'b0;
        is_mirrored_d = 1'b0;
        is_readonly_d = 1'b0;
        if (upperBank) begin
            ram_en_d = 1'b1;
        end else if (addrLo <= 16'h7FFF) begin
            ram_en_d = 1'b1;
        end else if (addrLo <= 16'h8FFF) begin
            ram_en_d      = 1'b1;
            is_mirrored_d = 1'b1;
        end else if (addrLo <= 16'hE7FF) begin
            ram_en_d      = 1'b1;
            is_readonly_d = 1'b1;
        end else if (addrLo[15:8] == 8'hE8) begin
            if (addrLo[7:4] == 4'h0) begin
                magic_en_d = 1'b1;
            end else if (addrLo[7:4] == 4'h1) begin
                pia1_en_d = 1'b1;
            end else if (addrLo[7:5] == 3'b001) begin
                pia2_en_d = 1'b1;
            end else if (addrLo[7:6] == 2'b01) begin
                via_en_d = 1'b1;
            end else begin
                crtc_en_d = 1'b1;
            end
        end else if (addrLo >= 16'hF000) begin
            ram_en_d      = 1'b1;
            is_readonly_d = 1'b1;
        end
    end

    // Magic registers live in the I/O page but are deliberately not part of io_en.
    assign io_en_d = pia1_en_d | pia2_en_d | via_en_d | crtc_en_d;

`ifdef ADDR_DECODE_REG_EN
    logic ram_en_q;
    logic magic_en_q;
    logic pia1_en_q;
    logic pia2_en_q;
    logic via_en_q;
    logic crtc_en_q;
    logic io_en_q;
    logic is_mirrored_q;
    logic is_readonly_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ram_en_q      <= 1'b0;
            magic_en_q    <= 1'b0;
            pia1_en_q     <= 1'b0;
            pia2_en_q     <= 1'b0;
            via_en_q      <= 1'b0;
            crtc_en_q     <= 1'b0;
            io_en_q       <= 1'b0;
            is_mirrored_q <= 1'b0;
            is_readonly_q <= 1'b0;
        end else begin
            ram_en_q      <= ram_en_d;
            magic_en_q    <= magic_en_d;
            pia1_en_q     <= pia1_en_d;
            pia2_en_q     <= pia2_en_d;
            via_en_q      <= via_en_d;
            crtc_en_q     <= crtc_en_d;
            io_en_q       <= io_en_d;
            is_mirrored_q <= is_mirrored_d;
            is_readonly_q <= is_readonly_d;
        end
    end

    assign ram_en_o      = ram_en_q;
    assign magic_en_o    = magic_en_q;
    assign pia1_en_o     = pia1_en_q;
    assign pia2_en_o     = pia2_en_q;
    assign via_en_o      = via_en_q;
    assign crtc_en_o     = crtc_en_q;
    assign io_en_o       = io_en_q;
    assign is_mirrored_o = is_mirrored_q;
    assign is_readonly_o = is_readonly_q;
`else
    // Clock and reset have no role in the combinational build.
    logic unused_clk_reset;
    assign unused_clk_reset = clk_i ^ reset_i;

    assign ram_en_o      = ram_en_d;
    assign magic_en_o    = magic_en_d;
    assign pia1_en_o     = pia1_en_d;
    assign pia2_en_o     = pia2_en_d;
    assign via_en_o      = via_en_d;
    assign crtc_en_o     = crtc_en_d;
    assign io_en_o       = io_en_d;
    assign is_mirrored_o = is_mirrored_d;
    assign is_readonly_o = is_readonly_d;
`endif

endmodule

// File: tb/tb_address_decoding.sv
// Scoreboard bench for address_decoding; expectations come from an independent range model.
// Works for both the combinational build and the ADDR_DECODE_REG_EN build.
module tb_address_decoding;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic [16:0] bus_addr_i = 17'h0;
    logic        ram_en_o;
    logic        magic_en_o;
    logic        pia1_en_o;
    logic        pia2_en_o;
    logic        via_en_o;
    logic        crtc_en_o;
    logic        io_en_o;
    logic        is_mirrored_o;
    logic        is_readonly_o;

`ifdef ADDR_DECODE_REG_EN
    localparam int LATENCY = 1;
`else
    localparam int LATENCY = 0;
`endif

    typedef struct {
        logic [8:0]  expected;
        logic [16:0] addr;
        int          due;
    } sbItem_t;

    sbItem_t sbQueue[$];
    int      cycle = 0;
    int      testsRun = 0;
    int      testsFailed = 0;

    address_decoding dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .bus_addr_i    (bus_addr_i),
        .ram_en_o      (ram_en_o),
        .magic_en_o    (magic_en_o),
        .pia1_en_o     (pia1_en_o),
        .pia2_en_o     (pia2_en_o),
        .via_en_o      (via_en_o),
        .crtc_en_o     (crtc_en_o),
        .io_en_o       (io_en_o),
        .is_mirrored_o (is_mirrored_o),
        .is_readonly_o (is_readonly_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cycle <= cycle + 1;

    // Bit order: ram, magic, pia1, pia2, via, crtc, io, mirrored, readonly.
    function automatic logic [8:0] modelDecode(input logic [16:0] a);
        logic [8:0] r;
        r = 9'b0;
        if (a >= 17'h10000)                        r = 9'b1_0000_0000;
        else if (a <= 17'h07FFF)                   r = 9'b1_0000_0000;
        else if (a <= 17'h08FFF)                   r = 9'b1_0000_0010;
        else if (a <= 17'h0E7FF)                   r = 9'b1_0000_0001;
        else if (a <= 17'h0E80F)                   r = 9'b0_1000_0000;
        else if (a <= 17'h0E81F)                   r = 9'b0_0100_0100;
        else if (a <= 17'h0E83F)                   r = 9'b0_0010_0100;
        else if (a <= 17'h0E87F)                   r = 9'b0_0001_0100;
        else if (a <= 17'h0E8FF)                   r = 9'b0_0000_1100;
        else if (a <= 17'h0EFFF)                   r = 9'b0_0000_0000;
        else                                       r = 9'b1_0000_0001;
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [8:0] observed, input logic [8:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %b, expected %b", tag, observed, expected);
        end
    endtask

    // Drive just after a rising edge; the expectation is due LATENCY edges later.
    task automatic applyStimulus(input logic [16:0] addr, input logic rst);
        sbItem_t item;
        @(posedge clk_i);
        #1;
        bus_addr_i = addr;
        reset_i    = rst;
        item.addr  = addr;
        item.due   = cycle + LATENCY;
        item.expected = (rst && LATENCY != 0) ? 9'b0 : modelDecode(addr);
        sbQueue.push_back(item);
    endtask

    initial begin
        sbItem_t item;
        logic [8:0] observed;
        forever begin
            @(negedge clk_i);
            while (sbQueue.size() > 0 && sbQueue[0].due <= cycle) begin
                item = sbQueue.pop_front();
                observed = {ram_en_o, magic_en_o, pia1_en_o, pia2_en_o, via_en_o,
                            crtc_en_o, io_en_o, is_mirrored_o, is_readonly_o};
                checkOutput($sformatf("addr_%05h", item.addr), observed, item.expected);
            end
        end
    end

    initial begin
        logic [16:0] boundaries[$];
        boundaries = '{17'h00000, 17'h07FFF, 17'h08000, 17'h08FFF, 17'h09000, 17'h0E7FF,
                       17'h0E800, 17'h0E80F, 17'h0E810, 17'h0E81F, 17'h0E820, 17'h0E83F,
                       17'h0E840, 17'h0E87F, 17'h0E880, 17'h0E8FF, 17'h0E900, 17'h0EFFF,
                       17'h0F000, 17'h0FFFF, 17'h10000, 17'h1E810, 17'h1FFFF};

        // Reset held for two edges on a PIA1 address, then released.
        applyStimulus(17'h0E810, 1'b1);
        applyStimulus(17'h0E810, 1'b1);
        applyStimulus(17'h0E810, 1'b0);
        applyStimulus(17'h08000, 1'b0);

        foreach (boundaries[i]) applyStimulus(boundaries[i], 1'b0);

        for (int a = 17'h0E800; a <= 17'h0E8FF; a++) applyStimulus(17'(a), 1'b0);

        for (int a = 0; a < 17'h20000; a += 17'h101) applyStimulus(17'(a), 1'b0);

        for (int i = 0; i < 200; i++) applyStimulus(17'($urandom_range(0, 17'h1FFFF)), 1'b0);

        for (int i = 0; i < 10 && sbQueue.size() > 0; i++) @(posedge clk_i);
        checkOutput("sb_drain", 9'(sbQueue.size()), 9'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
